button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 162 ++++++++++++++++
 rtl/button_conditioner.sv | 94 +++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the pushbutton conditioner.
// Holds the per-channel FSM state encoding, the direction index constants
// (bit3 up, bit2 down, bit1 left, bit0 right), the pending-move payload,
// and the debounce/repeat counter width function.
// Optional feature macro used by the block: BTN_AUTOREPEAT_EN.
package btn_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned DIR_W   = 2;

  // Direction index into btn_raw / btn_level / button_press.
  localparam logic [DIR_W-1:0] UP    = 2'd3;
  localparam logic [DIR_W-1:0] DOWN  = 2'd2;
  localparam logic [DIR_W-1:0] LEFT  = 2'd1;
  localparam logic [DIR_W-1:0] RIGHT = 2'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } btn_state_e;

  // One accepted move: valid flag plus direction index.
  typedef struct packed {
    logic             valid;
    logic [DIR_W-1:0] dir;
  } move_t;

  // Bits needed to hold the values 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count == 32'd0) ? 32'd1 : 32'($clog2(64'(max_count) + 64'd1));
  endfunction

  // Direction index to one-hot button vector.
  function automatic logic [NUM_BTN-1:0] dir_onehot(input logic [DIR_W-1:0] dir);
    return NUM_BTN'(1) << dir;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: 2-flop synchronizer, 4-state debounce FSM with a
// saturating stable-level counter, and (with BTN_AUTOREPEAT_EN defined) an
// auto-repeat timer active while the channel stays in PRESSED.
// Ports:
//   clk_65    in  system clock
//   rst       in  asynchronous active-high reset
//   btn_raw   in  asynchronous button level
//   btn_level out debounced level (1 in PRESSED and REL_DB)
//   press_evt out one-cycle press event (acceptance, or repeat when enabled)
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned REPEAT_DELAY    = 26000000,
  parameter int unsigned REPEAT_PERIOD   = 9750000
) (
  input  logic clk_65,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_evt
);

  localparam int unsigned       DB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  btn_state_e      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DB_W-1:0] db_inc;
  logic            level_q, level_d;
  logic            evt_q, evt_d;
  logic            accept;
  logic            rpt_fire;

  // Synchronizer stages.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Debounce FSM; the first qualifying sample seen in IDLE/PRESSED counts as 1.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    accept   = 1'b0;
    db_inc   = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + DB_W'(1);
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = DB_W'(1);
        end
      end
      PRESS_DB: begin
        if (!sync2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_inc >= DB_LIMIT) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
          accept   = 1'b1;
        end else begin
          db_cnt_d = db_inc;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d  = REL_DB;
          db_cnt_d = DB_W'(1);
        end
      end
      REL_DB: begin
        // A release glitch returning to PRESSED is not a new press.
        if (sync2_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_inc >= DB_LIMIT) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_inc;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == REL_DB);
    evt_d   = accept | rpt_fire;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned      RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                        : REPEAT_PERIOD;
  localparam int unsigned      RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RPT_W-1:0] rpt_inc;
  logic             rpt_first_q, rpt_first_d;

  // Repeat timer: counts clocks spent staying in PRESSED, first interval
  // REPEAT_DELAY then REPEAT_PERIOD; cleared whenever PRESSED is not held.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    rpt_inc     = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + RPT_W'(1);
    if ((state_q != PRESSED) || (state_d != PRESSED)) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (rpt_inc >= (rpt_first_q ? RPT_DLY : RPT_PER)) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b0;
      rpt_fire    = 1'b1;
    end else begin
      rpt_cnt_d = rpt_inc;
    end
  end

  always_ff @(posedge clk_65 or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  // Repeat timing parameters only matter when auto-repeat is built.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rpt_fire       = 1'b0;
`endif

  always_ff @(posedge clk_65 or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      evt_q    <= evt_d;
    end
  end

  assign btn_level = level_q;
  assign press_evt = evt_q;

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: per-channel debounce (btn_debounce x4), fixed
// priority arbitration of press events (up > down > left > right) and a
// one-entry pending move register handshaked with move_ready.
// Optional auto-repeat is built when BTN_AUTOREPEAT_EN is defined.
// Ports:
//   clk_65        in  system clock
//   rst           in  asynchronous active-high reset
//   btn_raw[3:0]  in  raw button levels (3 up, 2 down, 1 left, 0 right)
//   move_ready    in  consumer can take a move this cycle
//   button_press  out one-hot single-cycle move pulse
//   btn_level     out debounced button levels
//   press_pending out accepted move waiting for move_ready
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned REPEAT_DELAY    = 26000000,
  parameter int unsigned REPEAT_PERIOD   = 9750000
) (
  input  logic               clk_65,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               move_ready,
  output logic [NUM_BTN-1:0] button_press,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               press_pending
);

  logic [NUM_BTN-1:0] evt;
  move_t              win;
  move_t              pend_q, pend_d;
  logic [NUM_BTN-1:0] press_q, press_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_db (
      .clk_65    (clk_65),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .press_evt (evt[i])
    );
  end

  // Fixed-priority pick among this cycle's events; losers are dropped.
  always_comb begin
    win = '0;
    if (evt[UP]) begin
      win.valid = 1'b1;
      win.dir   = UP;
    end else if (evt[DOWN]) begin
      win.valid = 1'b1;
      win.dir   = DOWN;
    end else if (evt[LEFT]) begin
      win.valid = 1'b1;
      win.dir   = LEFT;
    end else if (evt[RIGHT]) begin
      win.valid = 1'b1;
      win.dir   = RIGHT;
    end
  end

  // Issue pending first; a same-cycle event then becomes pending. With nothing
  // pending and the consumer ready, the event bypasses straight to the pulse.
  always_comb begin
    pend_d  = pend_q;
    press_d = '0;
    if (pend_q.valid && move_ready) begin
      press_d = dir_onehot(pend_q.dir);
      pend_d  = win;
    end else if (win.valid && move_ready) begin
      press_d = dir_onehot(win.dir);
    end else if (win.valid) begin
      pend_d = win;
    end
  end

  always_ff @(posedge clk_65 or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      press_q <= '0;
    end else begin
      pend_q  <= pend_d;
      press_q <= press_d;
    end
  end

  assign button_press  = press_q;
  assign press_pending = pend_q.valid;

endmodule
